// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters
// with round-robin arbitration. Define UART_ARB_LOCK_EN to build packet
// locking (HOLD state, lock timer, o_abort); without it arbitration is per byte.
//
// Requester handshake: a requester raises i_req_valid[n] with i_req_data and
// i_req_last and holds all three stable until o_req_ready[n] pulses for one
// cycle; that pulse means the byte has been handed to uart_tx and the
// requester may present its next byte (or drop valid) on the following cycle.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [15:0] LOCK_TIMEOUT = 16'hFFFF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [7:0]             o_tx_char,
    output logic                   o_tx_write,
    input  logic                   i_tx_busy,
    output logic                   o_abort,
    output logic [1:0]             o_dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [7:0]      win_char;
    logic            win_last;

    assign o_dbg_state = state;

    // Round-robin search: first valid requester after ptr, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        win_char  = '0;
        win_last  = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
                win_char  = i_req_data[idx*8 +: 8];
                win_last  = i_req_last[idx];
            end
        end
    end

`ifdef UART_ARB_LOCK_EN
    logic            last_q;
    logic [15:0]     timer;
    logic            own_valid;
    logic [7:0]      own_char;
    logic            own_last;

    // Current owner's request, used to continue a locked message.
    always_comb begin
        own_valid = 1'b0;
        own_char  = '0;
        own_last  = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (PW'(n) == ptr) begin
                own_valid = i_req_valid[n];
                own_char  = i_req_data[n*8 +: 8];
                own_last  = i_req_last[n];
            end
        end
    end

    // Arbiter FSM with packet locking; all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            ptr         <= PW'(NUM_REQ - 1);
            o_req_ready <= '0;
            o_grant     <= '0;
            o_tx_char   <= '0;
            o_tx_write  <= 1'b0;
            o_abort     <= 1'b0;
            last_q      <= 1'b0;
            timer       <= '0;
        end else begin
            o_req_ready <= '0;
            o_abort     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_tx_busy && win_found) begin
                        ptr        <= win_idx;
                        o_grant    <= ONE << win_idx;
                        o_tx_char  <= win_char;
                        last_q     <= win_last;
                        o_tx_write <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_busy) begin
                        o_tx_write  <= 1'b0;
                        o_req_ready <= o_grant;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!i_tx_busy) begin
                        if (!last_q) begin
                            timer <= '0;
                            state <= ST_HOLD;
                        end else begin
                            o_grant <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (own_valid) begin
                        o_tx_char  <= own_char;
                        last_q     <= own_last;
                        o_tx_write <= 1'b1;
                        timer      <= '0;
                        state      <= ST_SEND;
                    end else if (timer + 16'd1 == LOCK_TIMEOUT) begin
                        o_abort <= 1'b1;
                        o_grant <= '0;
                        timer   <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    o_grant <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
`else
    // Without locking, last flags and the timeout value have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{i_req_last, LOCK_TIMEOUT, win_last};
    assign o_abort    = 1'b0;

    // Arbiter FSM, one byte per grant; all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            ptr         <= PW'(NUM_REQ - 1);
            o_req_ready <= '0;
            o_grant     <= '0;
            o_tx_char   <= '0;
            o_tx_write  <= 1'b0;
        end else begin
            o_req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (!i_tx_busy && win_found) begin
                        ptr        <= win_idx;
                        o_grant    <= ONE << win_idx;
                        o_tx_char  <= win_char;
                        o_tx_write <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_busy) begin
                        o_tx_write  <= 1'b0;
                        o_req_ready <= o_grant;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!i_tx_busy) begin
                        o_grant <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    o_grant <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx (busy one cycle after
// write is sampled, fixed byte time). Packet-lock scenarios are included when
// UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int          NUM_REQ  = 4;
  localparam logic [15:0] LOCK_TO  = 16'd8;
  localparam int          BYTE_CYC = 12;
  localparam int          W        = 12;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic [7:0]           o_tx_char;
  logic                 o_tx_write;
  logic                 tx_busy = 1'b0;
  logic                 o_abort;
  logic [1:0]           o_dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int abort_cnt = 0;
  int total_bytes = 0;
  int wr_len = 0;
  int hold_cnt = 0;
  int busy_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   byte_q[NUM_REQ][$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_char   (o_tx_char),
    .o_tx_write  (o_tx_write),
    .i_tx_busy   (tx_busy),
    .o_abort     (o_abort),
    .o_dbg_state (o_dbg_state)
  );

  // clock
  always #5 i_clk = ~i_clk;

  // uart_tx model: ignores arbiter reset, finishes any byte it holds
  always @(posedge i_clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end else if (o_tx_write && !tx_busy) begin
      tx_busy  <= 1'b1;
      busy_cnt <= BYTE_CYC;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_tx_write && !tx_busy) begin
      if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
      else check("tx_byte", {o_grant, o_tx_char}, exp_q.pop_front());
    end
    if (o_tx_write) wr_len++;
    else if (wr_len != 0) begin
      check("write_len", wr_len, 2);
      wr_len = 0;
    end
    if (o_req_ready != '0) begin
      check("ready_owner", o_req_ready, o_grant);
      ready_cnt++;
    end
    if (o_abort) begin
      check("abort_delay", hold_cnt, LOCK_TO);
      abort_cnt++;
    end
    if (o_dbg_state == 2'd3) hold_cnt++;
    else hold_cnt = 0;
  end

  task automatic queue_byte(input int n, input logic [7:0] d, input logic last);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << n;
    byte_q[n].push_back({last, d});
    exp_q.push_back({oh, d});
    total_bytes++;
  endtask

  task automatic present();
    logic [8:0] f;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (byte_q[n].size() > 0) begin
        f = byte_q[n][0];
        req_valid[n] = 1'b1;
        req_data[n*8 +: 8] = f[7:0];
        req_last[n] = f[8];
      end else begin
        req_valid[n] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    for (int n = 0; n < NUM_REQ; n++)
      if (o_req_ready[n] && byte_q[n].size() > 0) void'(byte_q[n].pop_front());
    present();
  endtask

  function automatic bit reqs_empty();
    for (int n = 0; n < NUM_REQ; n++)
      if (byte_q[n].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic service(input string tag, input int budget);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    present();
    while (!done && cyc < budget) begin
      step();
      cyc++;
      done = reqs_empty() && exp_q.size() == 0 && !tx_busy &&
             o_grant == '0 && o_dbg_state == 2'd0;
    end
    check(tag, done, 1);
    if (!done) begin
      for (int n = 0; n < NUM_REQ; n++) byte_q[n].delete();
      exp_q.delete();
      present();
    end
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d exp=idle", o_dbg_state);
    $fatal(1);
  end

  initial begin
    int exp_aborts;
    int cyc;
    exp_aborts = 0;

    // reset values
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_grant", o_grant, 0);
    check("rst_write", o_tx_write, 0);
    check("rst_char", o_tx_char, 0);
    check("rst_ready", o_req_ready, 0);
    check("rst_abort", o_abort, 0);
    check("rst_state", o_dbg_state, 0);
    #2;
    i_rst_n = 1'b1;

    // contention: two rounds, each starting at req0
    for (int n = 0; n < NUM_REQ; n++) queue_byte(n, 8'(8'h10 + n), 1'b1);
    for (int n = 0; n < NUM_REQ; n++) queue_byte(n, 8'(8'h20 + n), 1'b1);
    service("contention_done", 400);

    // single byte
    queue_byte(0, 8'h41, 1'b1);
    service("single_done", 100);
    check("single_grant_idle", o_grant, 0);

    // random single requesters
    for (int k = 0; k < 6; k++) begin
      queue_byte($urandom_range(0, NUM_REQ-1), 8'($urandom_range(0, 255)), 1'b1);
      service("rand_done", 100);
    end

    // reset mid-byte, in DRAIN
    apply_reset();
    queue_byte(0, 8'h55, 1'b1);
    present();
    cyc = 0;
    while (o_dbg_state != 2'd2 && cyc < 50) begin
      step();
      cyc++;
    end
    check("reach_drain", o_dbg_state, 2);
    step();
    #1;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_grant", o_grant, 0);
    check("mid_rst_char", o_tx_char, 0);
    check("mid_rst_write", o_tx_write, 0);
    check("mid_rst_state", o_dbg_state, 0);
    queue_byte(1, 8'h77, 1'b1);
    queue_byte(0, 8'h66, 1'b1);
    exp_q.delete();
    exp_q.push_back({4'b0001, 8'h66});
    exp_q.push_back({4'b0010, 8'h77});
    present();
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    cyc = 0;
    while (tx_busy && cyc < 50) begin
      @(posedge i_clk);
      #1;
      if (tx_busy) check("rst_no_grant", o_grant, 0);
      cyc++;
    end
    service("post_rst_done", 200);

`ifdef UART_ARB_LOCK_EN
    // packet lock: "AB" from req1 is not interleaved with req2's 'Z'
    apply_reset();
    queue_byte(1, 8'h41, 1'b0);
    queue_byte(1, 8'h42, 1'b1);
    queue_byte(2, 8'h5A, 1'b1);
    service("lock_done", 300);

    // lock timeout: req3 stalls mid-message, req0 waiting
    queue_byte(3, 8'h33, 1'b0);
    queue_byte(0, 8'h30, 1'b1);
    service("timeout_done", 300);
    exp_aborts = 1;
`endif

    check("ready_total", ready_cnt, total_bytes);
    check("abort_count", abort_cnt, exp_aborts);
    check("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters, such as the CPU console port and debug/trace sources. Arbitration is round-robin, with optional packet locking so that multi-byte messages are not interleaved. The block sits between the requesters and `uart_tx`. It drives `uart_tx.i_write`/`i_char` and observes `o_busy`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `LOCK_TIMEOUT`, default 65535: idle cycles a locked requester may stall before its lock is revoked; 16-bit.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous reset, active-low.
- `i_req_valid`  in  NUM_REQ  requester n has a byte pending.
- `i_req_data`  in  8*NUM_REQ  byte for requester n, at bits [8n+7:8n].
- `i_req_last`  in  NUM_REQ  byte is the last byte of its message.
- `o_req_ready`  out  NUM_REQ  one-cycle pulse: byte from requester n has been consumed.
- `o_grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `o_tx_char`  out  8  connects to `uart_tx.i_char`.
- `o_tx_write`  out  1  connects to `uart_tx.i_write`.
- `i_tx_busy`  in  1  connects to `uart_tx.o_busy`.
- `o_abort`  out  1  one-cycle pulse: lock revoked by timeout.

## Operation
- States: IDLE, SEND, DRAIN, HOLD.
- Requester rule: hold `valid`, `data` and `last` stable from assertion until `o_req_ready` pulses.
  - Dropping `valid` earlier is a protocol violation.
  - The arbiter still transmits the byte it already latched.
- IDLE:
  - Arbitrates only when `i_tx_busy`=0 and any `valid` is set.
  - Winner is the first set `valid` searching from `ptr+1` upward, wrapping modulo NUM_REQ.
  - On that edge: `ptr`←winner, `o_grant`←one-hot(winner), `o_tx_char`←data, `last_q`←last, `o_tx_write`←1, go SEND.
- SEND:
  - Hold `o_tx_write`=1 until `i_tx_busy`=1 is sampled.
  - On that edge: `o_tx_write`←0, `o_req_ready[owner]`←1 for one cycle, go DRAIN.
- DRAIN:
  - Wait for `i_tx_busy`=0.
  - Then go IDLE, clearing `o_grant`, or go HOLD when locking applies (see Configuration).
- HOLD, owner keeps grant:
  - If `valid[owner]`: load char/last, `o_tx_write`←1, go SEND, clear the timer.
  - Otherwise increment the 16-bit timer. When it equals `LOCK_TIMEOUT`: `o_abort` pulses, `o_grant`←0, go IDLE.
- `ptr` resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- Reset mid-operation:
  - All outputs clear immediately; state goes to IDLE.
  - A byte already inside `uart_tx` finishes on its own.
  - IDLE does not grant until `i_tx_busy` falls.

## Timing
- Reset values: `o_req_ready`=0, `o_grant`=0, `o_tx_char`=0, `o_tx_write`=0, `o_abort`=0, timer=0, `ptr`=NUM_REQ-1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- With `uart_tx` (busy rises one cycle after write is sampled), per byte:
  - edge E0: grant and write rise;
  - E1: `uart_tx` latches the byte;
  - E2: write falls and ready pulses during E2..E3.
  - `o_tx_write` is high for exactly 2 cycles.
- Byte-to-byte gap is one IDLE or HOLD cycle after `i_tx_busy` falls.
- A `valid` arriving while SEND/DRAIN is in progress waits; requests are never dropped.
- Simultaneous requests are resolved purely by `ptr` order. Each requester is granted at most once per NUM_REQ grants while others are pending.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - After DRAIN, if `last_q`=0 go to HOLD; otherwise go IDLE.
  - Messages are atomic unless the timeout fires.
- `UART_ARB_LOCK_EN` undefined:
  - DRAIN always goes to IDLE; arbitration is per byte.
  - `i_req_last` is ignored and `LOCK_TIMEOUT` is unused.
  - HOLD and the timer are not built; `o_abort` is tied 0.

## Test plan
- Single byte. Req0 sends 0x41, last=1.
  - Expect `o_tx_write` high 2 cycles with char 0x41 and one `o_req_ready[0]` pulse.
  - Serial line shows 0x41; `o_grant` returns to 0.
- Contention, lock off. Req0..3 all valid with one byte each (0x10..0x13).
  - Expect transmit order 0x10, 0x11, 0x12, 0x13.
  - Then a second round starting at req0.
- Packet lock (LOCK_EN). Req1 sends "AB", last on B; req2 valid throughout with 'Z'.
  - Expect line order A, B, Z. `o_grant` stays 0b0010 through HOLD.
- Lock timeout. `LOCK_TIMEOUT`=8; req3 sends one byte with last=0, then drops valid.
  - Expect `o_abort` pulse 8 cycles after entering HOLD.
  - Pending req0 is granted next.
- Reset mid-byte. Assert `i_rst_n`=0 during DRAIN.
  - Outputs are 0 at once.
  - After release, no grant until `i_tx_busy`=0, then req0 is granted first.
